mem_arbiter: RTL

Shares one single-port memory bus between the instruction-fetch and load/store requesters of the RV32 core. It serializes their transactions, routes each response back to its owner, and drives the `stall` input of the instruction decoder while any requester is waiting. Data accesses have priority, with a starvation guard for fetch, and a bus watchdog converts a hung transaction into an error response.

---
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory bus signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction-fetch requester
  logic                    imem_req;
  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  logic [DATA_WIDTH-1:0]   imem_rdata;
  logic                    imem_err;

  // load/store requester
  logic                    dmem_req;
  logic                    dmem_we;
  logic [DATA_WIDTH/8-1:0] dmem_be;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic                    dmem_gnt;
  logic                    dmem_rvalid;
  logic [DATA_WIDTH-1:0]   dmem_rdata;
  logic                    dmem_err;

  // shared single-port memory bus
  logic                    bus_req;
  logic                    bus_we;
  logic [DATA_WIDTH/8-1:0] bus_be;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic                    bus_ack;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  // decoder stall
  logic                    stall;

  // arbiter view
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata,
    output stall
  );

  // core requesters plus memory view
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ack, bus_rdata,
    input  stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for one single-port memory bus
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           resetn,
  mem_arbiter_if.slave   io
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // last watchdog count before an unacknowledged access is aborted
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] starve;
  logic [7:0] wdog;
  logic       pick_d;
  logic       pick_i;
  logic       finish;

  // data wins unless fetch has lost two grants in a row; grants only in IDLE and never during reset
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (resetn && state == IDLE) begin
      pick_d = io.dmem_req && !(io.imem_req && starve == 2'd2);
      pick_i = io.imem_req && !pick_d;
    end
    finish = io.bus_ack || (wdog == WD_LAST);
  end

  assign io.imem_gnt = pick_i;
  assign io.dmem_gnt = pick_d;
  assign io.stall    = resetn && ((io.imem_req && !pick_i) ||
                                  (io.dmem_req && !pick_d) ||
                                  (state != IDLE));

  // arbiter FSM: latch the winner onto the bus, then wait for ack or watchdog expiry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      starve         <= 2'd0;
      wdog           <= 8'd0;
      io.bus_req     <= 1'b0;
      io.bus_we      <= 1'b0;
      io.bus_be      <= '0;
      io.bus_addr    <= '0;
      io.bus_wdata   <= '0;
      io.imem_rvalid <= 1'b0;
      io.imem_rdata  <= '0;
      io.imem_err    <= 1'b0;
      io.dmem_rvalid <= 1'b0;
      io.dmem_rdata  <= '0;
      io.dmem_err    <= 1'b0;
    end else begin
      io.imem_rvalid <= 1'b0;
      io.dmem_rvalid <= 1'b0;
      io.imem_err    <= 1'b0;
      io.dmem_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            io.bus_req   <= 1'b1;
            io.bus_we    <= io.dmem_we;
            io.bus_be    <= io.dmem_be;
            io.bus_addr  <= io.dmem_addr;
            io.bus_wdata <= io.dmem_wdata;
            wdog         <= 8'd0;
            state        <= BUSY_D;
            if (io.imem_req) starve <= starve + 2'd1;
          end else if (pick_i) begin
            io.bus_req   <= 1'b1;
            io.bus_we    <= 1'b0;
            io.bus_be    <= '1;
            io.bus_addr  <= io.imem_addr;
            io.bus_wdata <= '0;
            wdog         <= 8'd0;
            starve       <= 2'd0;
            state        <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (finish) begin
            // an ack in the expiry cycle still counts as a normal completion
            io.bus_req <= 1'b0;
            state      <= IDLE;
            if (state == BUSY_I) begin
              io.imem_rvalid <= 1'b1;
              io.imem_err    <= !io.bus_ack;
              io.imem_rdata  <= (io.bus_ack && !io.bus_we) ? io.bus_rdata : '0;
            end else begin
              io.dmem_rvalid <= 1'b1;
              io.dmem_err    <= !io.bus_ack;
              io.dmem_rdata  <= (io.bus_ack && !io.bus_we) ? io.bus_rdata : '0;
            end
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
